periph_bus_arbiter: RTL and testbench

- Shares the single memory-mapped peripheral bus (timer, LED, switch, digit, UART registers at 0x4000_0000–0x4000_0020) between two requesters.
- m0 is the CPU data port. m1 is a secondary master, e.g. a UART DMA/loader engine.
- The peripheral side has a combinational read and a write committed on the clock edge, so one granted cycle is one complete transaction.
- Round-robin arbitration, with an optional lock for bounded back-to-back bursts.

---
 rtl/periph_bus_arbiter.sv | 136 +++++++++++++
 tb/tb_periph_bus_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/periph_bus_arbiter.sv
// Two-master round-robin arbiter for the single-cycle peripheral bus, with bounded lock bursts.
// Define PERIPH_ARB_FIXED_PRIO_EN for fixed m0 priority (m1 lock still bounded by BURST_MAX).
module periph_bus_arbiter #(
    parameter int unsigned BURST_MAX = 4,
    parameter int unsigned CNT_W     = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_rd,
    input  logic        m1_rd,
    input  logic        m0_wr,
    input  logic        m1_wr,
    input  logic        m0_lock,
    input  logic        m1_lock,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    input  logic [31:0] Read_data,
    output logic [1:0]  grant,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] BURST_LIM = CNT_W'(BURST_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    state_t           state_q, state_d;
    logic             last_owner_q, last_owner_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;
    logic             keep1;
`ifndef PERIPH_ARB_FIXED_PRIO_EN
    logic             keep0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= 1'b1;
            burst_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

    // Next owner and tenure bookkeeping.
    always_comb begin
        state_d      = IDLE;
        last_owner_d = last_owner_q;
        burst_cnt_d  = '0;
        keep1 = (state_q == OWN1) && m1_lock && (burst_cnt_q < BURST_LIM);
`ifndef PERIPH_ARB_FIXED_PRIO_EN
        keep0 = (state_q == OWN0) && m0_lock && (burst_cnt_q < BURST_LIM);
`endif

        unique case ({m1_req, m0_req})
            2'b00: state_d = IDLE;
            2'b01: state_d = OWN0;
            2'b10: state_d = OWN1;
            default: begin
`ifdef PERIPH_ARB_FIXED_PRIO_EN
                state_d = keep1 ? OWN1 : OWN0;
`else
                if (keep0)
                    state_d = OWN0;
                else if (keep1)
                    state_d = OWN1;
                else
                    state_d = last_owner_q ? OWN0 : OWN1;
`endif
            end
        endcase

        if (state_d == OWN0)
            last_owner_d = 1'b0;
        else if (state_d == OWN1)
            last_owner_d = 1'b1;

        if ((state_d == state_q) && (state_q != IDLE))
            burst_cnt_d = (burst_cnt_q == CNT_MAX) ? burst_cnt_q : burst_cnt_q + 1'b1;
    end

    // Bus mux; outputs depend on the registered owner so async reset zeroes them at once.
    always_comb begin
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        Address    = '0;
        Write_data = '0;
        m0_ack     = 1'b0;
        m1_ack     = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        grant      = 2'b00;
        busy       = (state_q != IDLE);

        unique case (state_q)
            OWN0: begin
                grant      = 2'b01;
                Address    = m0_addr;
                Write_data = m0_wdata;
                MemWrite   = m0_req & m0_wr;
                MemRead    = m0_req & m0_rd & ~m0_wr;
                m0_ack     = m0_req;
                m0_rdata   = m0_req ? Read_data : '0;
            end
            OWN1: begin
                grant      = 2'b10;
                Address    = m1_addr;
                Write_data = m1_wdata;
                MemWrite   = m1_req & m1_wr;
                MemRead    = m1_req & m1_rd & ~m1_wr;
                m1_ack     = m1_req;
                m1_rdata   = m1_req ? Read_data : '0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Scoreboard bench for periph_bus_arbiter: directed transactions queue their expected bus cycle,
// a negedge monitor pops one entry per ack and compares the full bus picture.
module tb_periph_bus_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req, m1_req, m0_rd, m1_rd, m0_wr, m1_wr, m0_lock, m1_lock;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        MemRead, MemWrite;
    logic [31:0] Address, Write_data, Read_data;
    logic [1:0]  grant;
    logic        busy;

    periph_bus_arbiter #(.BURST_MAX(4), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m1_req(m1_req), .m0_rd(m0_rd), .m1_rd(m1_rd),
        .m0_wr(m0_wr), .m1_wr(m1_wr), .m0_lock(m0_lock), .m1_lock(m1_lock),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .Address(Address), .Write_data(Write_data),
        .Read_data(Read_data), .grant(grant), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Peripheral register file: combinational read, write on the clock edge.
    logic [31:0] mem [16];
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h0;
        mem[1] = 32'h0000_0011;
        mem[2] = 32'h0000_0022;
        mem[4] = 32'h0000_003C;
    end
    always @(posedge clk) if (MemWrite) mem[Address[5:2]] <= Write_data;
    assign Read_data = mem[Address[5:2]];

    typedef struct {
        logic        own;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    txn_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"},  32'(grant),      32'h0);
        chk({tag, "_busy"},   32'(busy),       32'h0);
        chk({tag, "_mrd"},    32'(MemRead),    32'h0);
        chk({tag, "_mwr"},    32'(MemWrite),   32'h0);
        chk({tag, "_addr"},   Address,         32'h0);
        chk({tag, "_wdata"},  Write_data,      32'h0);
        chk({tag, "_ack0"},   32'(m0_ack),     32'h0);
        chk({tag, "_ack1"},   32'(m1_ack),     32'h0);
        chk({tag, "_rdata0"}, m0_rdata,        32'h0);
        chk({tag, "_rdata1"}, m1_rdata,        32'h0);
    endtask

    always @(negedge clk) begin
        if (reset && (m0_ack || m1_ack)) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack0=%0b ack1=%0b, expected none (t=%0t)",
                         m0_ack, m1_ack, $time);
            end else begin
                txn_t e;
                e = sb.pop_front();
                chk("grant",   32'(grant), e.own ? 32'h2 : 32'h1);
                chk("busy",    32'(busy), 32'h1);
                chk("MemRead", 32'(MemRead), 32'(e.rd & ~e.wr));
                chk("MemWrite", 32'(MemWrite), 32'(e.wr));
                chk("Address", Address, e.addr);
                chk("Write_data", Write_data, e.wdata);
                if (e.own) begin
                    chk("m1_ack", 32'(m1_ack), 32'h1);
                    chk("m1_rdata", m1_rdata, e.rdata);
                    chk("m0_ack_off", 32'(m0_ack), 32'h0);
                    chk("m0_rdata_off", m0_rdata, 32'h0);
                end else begin
                    chk("m0_ack", 32'(m0_ack), 32'h1);
                    chk("m0_rdata", m0_rdata, e.rdata);
                    chk("m1_ack_off", 32'(m1_ack), 32'h0);
                    chk("m1_rdata_off", m1_rdata, 32'h0);
                end
            end
        end
    end

    task automatic drv0(input logic req, rd, wr, lock, input logic [31:0] addr, wdata);
        m0_req = req; m0_rd = rd; m0_wr = wr; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    endtask

    task automatic drv1(input logic req, rd, wr, lock, input logic [31:0] addr, wdata);
        m1_req = req; m1_rd = rd; m1_wr = wr; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    endtask

    task automatic push(input logic own, rd, wr, input logic [31:0] addr, wdata, rdata);
        txn_t t;
        t.own = own; t.rd = rd; t.wr = wr; t.addr = addr; t.wdata = wdata; t.rdata = rdata;
        sb.push_back(t);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drv0(0, 0, 0, 0, 32'h0, 32'h0);
        drv1(0, 0, 0, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    initial begin
        // Reset state must hold even with a request pending on the inputs.
        reset = 1'b0;
        drv0(1, 0, 1, 0, 32'h4000_000C, 32'h0000_00A5);
        drv1(1, 1, 0, 1, 32'h4000_0010, 32'h0);
        #3;
        chk_idle("reset");
        do_reset();

        // Test 1: single m0 write.
        cyc();
        drv0(1, 0, 1, 0, 32'h4000_000C, 32'h0000_00A5);
        push(0, 0, 1, 32'h4000_000C, 32'h0000_00A5, 32'h0);
        cyc();
        cyc();
        drv0(0, 0, 0, 0, 32'h0, 32'h0);
        @(negedge clk);
        chk("t1_after_mwr",  32'(MemWrite), 32'h0);
        chk("t1_after_mrd",  32'(MemRead),  32'h0);
        chk("t1_after_ack0", 32'(m0_ack),   32'h0);
        chk("t1_after_addr", Address,       32'h0);
        cyc();
        @(negedge clk);
        chk_idle("t1_idle");
        chk("t1_mem3", mem[3], 32'h0000_00A5);

        // Test 2: unlocked contention from reset alternates m0, m1, m0, m1.
        do_reset();
        cyc();
        drv0(1, 1, 0, 0, 32'h4000_0004, 32'h0);
        drv1(1, 1, 0, 0, 32'h4000_0008, 32'h0);
        push(0, 1, 0, 32'h4000_0004, 32'h0, 32'h0000_0011);
        push(1, 1, 0, 32'h4000_0008, 32'h0, 32'h0000_0022);
        push(0, 1, 0, 32'h4000_0004, 32'h0, 32'h0000_0011);
        push(1, 1, 0, 32'h4000_0008, 32'h0, 32'h0000_0022);
        repeat (4) cyc();
        drv0(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        drv1(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        @(negedge clk);
        chk("t2_busy", 32'(busy), 32'h0);
        chk("t2_sb_drained", 32'(sb.size()), 32'h0);

        // Test 3: locked m1 keeps the bus for BURST_MAX grants while m0 waits.
        cyc();
        drv1(1, 1, 0, 1, 32'h4000_0008, 32'h0);
        push(1, 1, 0, 32'h4000_0008, 32'h0, 32'h0000_0022);
        push(1, 1, 0, 32'h4000_0008, 32'h0, 32'h0000_0022);
        push(1, 1, 0, 32'h4000_0008, 32'h0, 32'h0000_0022);
        push(1, 1, 0, 32'h4000_0008, 32'h0, 32'h0000_0022);
        push(0, 1, 0, 32'h4000_0004, 32'h0, 32'h0000_0011);
        cyc();
        drv0(1, 1, 0, 0, 32'h4000_0004, 32'h0);
        repeat (4) cyc();
        drv1(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        drv0(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        @(negedge clk);
        chk("t3_busy", 32'(busy), 32'h0);
        chk("t3_sb_drained", 32'(sb.size()), 32'h0);

        // Test 4: m1 read returns peripheral data; m0 side stays quiet.
        cyc();
        drv1(1, 1, 0, 0, 32'h4000_0010, 32'h0);
        push(1, 1, 0, 32'h4000_0010, 32'h0, 32'h0000_003C);
        cyc();
        cyc();
        drv1(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();

        // Test 5: rd and wr together is a write.
        cyc();
        drv0(1, 1, 1, 0, 32'h4000_0020, 32'h0000_005A);
        push(0, 1, 1, 32'h4000_0020, 32'h0000_005A, 32'h0);
        cyc();
        cyc();
        drv0(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        @(negedge clk);
        chk("t5_mem8", mem[8], 32'h0000_005A);

        // Test 6: async reset during an m1 write aborts it; first tie afterwards goes to m0.
        cyc();
        drv1(1, 0, 1, 0, 32'h4000_0014, 32'h0000_0077);
        cyc();
        chk("t6_pending_mwr", 32'(MemWrite), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("t6_rst_mwr",   32'(MemWrite), 32'h0);
        chk("t6_rst_grant", 32'(grant),    32'h0);
        chk("t6_rst_busy",  32'(busy),     32'h0);
        chk("t6_rst_ack1",  32'(m1_ack),   32'h0);
        @(posedge clk);
        @(negedge clk);
        drv1(0, 0, 0, 0, 32'h0, 32'h0);
        #2 reset = 1'b1;
        chk("t6_mem5", mem[5], 32'h0);
        cyc();
        drv0(1, 1, 0, 0, 32'h4000_0004, 32'h0);
        drv1(1, 1, 0, 0, 32'h4000_0008, 32'h0);
        push(0, 1, 0, 32'h4000_0004, 32'h0, 32'h0000_0011);
        cyc();
        cyc();
        drv0(0, 0, 0, 0, 32'h0, 32'h0);
        drv1(0, 0, 0, 0, 32'h0, 32'h0);
        cyc();
        cyc();
        @(negedge clk);
        chk("final_busy", 32'(busy), 32'h0);
        chk("final_sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
